// File: rtl/seg_pkg.sv
// Shared seven-segment constants: display geometry and active-low hex patterns.
package seg_pkg;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;
    localparam int SAMPLE_W = DIGITS + 1 + SEG_W;

    // Entry n is the {CG..CA} active-low pattern that shows hex digit n.
    localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment decoder: active-low {CG..CA} pattern to a hex nibble.
module seg_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]    seg,
    output logic                hit,
    output logic [NIBBLE_W-1:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_PATTERNS[i]) begin
                hit    = 1'b1;
                nibble = NIBBLE_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Seven-segment scan monitor: rebuilds the 32-bit word shown on a multiplexed display.
// Build option SEG_CAPTURE_DP_EN captures decimal points per digit; otherwise DP is ignored.
module seg_capture
    import seg_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        CA,
    input  logic        CB,
    input  logic        CC,
    input  logic        CD,
    input  logic        CE,
    input  logic        CF,
    input  logic        CG,
    input  logic        DP,
    input  logic [7:0]  AN,
    output logic [31:0] data,
    output logic [7:0]  dp,
    output logic        valid,
    output logic        frame_err,
    output logic        err
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam int CLK_FREQUENCY_UNUSED = CLK_FREQUENCY;

    logic [SAMPLE_W-1:0]        pins;
    logic [SAMPLE_W-1:0]        sample;
    logic [CNT_W-1:0]           count;
    logic                       taken;
    logic [DIGITS-1:0]          mask;
    logic [DIGITS-1:0]          mask_next;
    logic [DIGITS-1:0]          dpshadow;
    logic [DIGITS*NIBBLE_W-1:0] shadow;
    logic                       sticky;
    logic                       sticky_next;
    logic                       change;
    logic                       accept;
    logic                       frame_done;
    logic                       store;
    logic                       bad;
    logic [DIGITS-1:0]          an_sel;
    logic                       hit;
    logic [NIBBLE_W-1:0]        nibble;

    // The DP slot holds "point lit" so a disabled build can tie it to zero.
`ifdef SEG_CAPTURE_DP_EN
    assign pins = {AN, ~DP, CG, CF, CE, CD, CC, CB, CA};
`else
    logic dp_unused;
    assign dp_unused = DP;
    assign pins = {AN, 1'b0, CG, CF, CE, CD, CC, CB, CA};
`endif

    seg_decode u_decode (
        .seg    (sample[SEG_W-1:0]),
        .hit    (hit),
        .nibble (nibble)
    );

    assign an_sel     = ~sample[SAMPLE_W-1 -: DIGITS];
    assign change     = (pins != sample);
    assign accept     = en && !change && !taken && (count == CNT_MAX);
    assign frame_done = (mask == '1);

    always_comb begin
        mask_next   = frame_done ? '0 : mask;
        sticky_next = frame_done ? 1'b0 : sticky;
        store       = 1'b0;
        bad         = 1'b0;
        if (accept && (an_sel != '0)) begin
            if ($onehot(an_sel)) begin
                store     = 1'b1;
                mask_next = mask_next | an_sel;
                if (!hit) begin
                    bad         = 1'b1;
                    sticky_next = 1'b1;
                end
            end else begin
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample    <= '0;
            count     <= '0;
            taken     <= 1'b0;
            mask      <= '0;
            sticky    <= 1'b0;
            shadow    <= '0;
            dpshadow  <= '0;
            data      <= '0;
            dp        <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            err       <= 1'b0;
        end else begin
            sample <= pins;
            valid  <= 1'b0;
            err    <= 1'b0;
            if (!en) begin
                count  <= '0;
                taken  <= 1'b0;
                mask   <= '0;
                sticky <= 1'b0;
            end else begin
                if (change) begin
                    count <= '0;
                    taken <= 1'b0;
                end else begin
                    if (count != CNT_MAX) begin
                        count <= count + 1'b1;
                    end
                    if (accept && (an_sel != '0)) begin
                        taken <= 1'b1;
                    end
                end
                err    <= bad;
                mask   <= mask_next;
                sticky <= sticky_next;
                if (store) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (an_sel[i]) begin
                            shadow[i*NIBBLE_W +: NIBBLE_W] <= hit ? nibble : '0;
                            dpshadow[i] <= sample[SEG_W];
                        end
                    end
                end
                // Frame publishes the cycle after the last missing digit lands.
                if (frame_done) begin
                    data      <= shadow;
                    dp        <= dpshadow;
                    frame_err <= sticky;
                    valid     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scan scenarios plus a randomized scan model.
`timescale 1ns/1ps
module tb_seg_capture;

    localparam int SC = 16;

`ifdef SEG_CAPTURE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_n;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        valid;
    logic        frame_err;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int valid_total  = 0;
    int err_total    = 0;
    int valid_cyc    = 0;
    int err_cyc      = 0;
    int last_start   = 0;
    int exp_err      = 0;
    logic [7:0]  prev_an = 8'hFF;
    logic [40:0] got_q [$];
    logic [40:0] exp_q [$];

    logic [6:0] pat [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [3:0] m_val [8];
    bit         m_cov [8];
    bit         m_dp  [8];
    bit         m_bad;

    seg_capture #(
        .CLK_FREQUENCY (100_000_000),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .CA        (seg_r[0]),
        .CB        (seg_r[1]),
        .CC        (seg_r[2]),
        .CD        (seg_r[3]),
        .CE        (seg_r[4]),
        .CF        (seg_r[5]),
        .CG        (seg_r[6]),
        .DP        (dp_n),
        .AN        (an_r),
        .data      (data),
        .dp        (dp),
        .valid     (valid),
        .frame_err (frame_err),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid === 1'b1) begin
                valid_total = valid_total + 1;
                valid_cyc   = cyc;
                got_q.push_back({frame_err, dp, data});
            end
            if (err === 1'b1) begin
                err_total = err_total + 1;
                err_cyc   = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got %0d cycles required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_cov[i] = 1'b0;
            m_val[i] = 4'h0;
            m_dp[i]  = 1'b0;
        end
        m_bad = 1'b0;
    endtask

    // A strobe held SC+1 cycles or longer counts once; the frame closes on full digit coverage.
    task automatic model_strobe(input logic [7:0] an, input logic [6:0] seg, input bit lit, input int len);
        int zeros;
        int d;
        int val;
        bit all;
        logic [31:0] dat;
        logic [7:0]  dpv;
        if (en !== 1'b1 || len < SC + 1 || an == 8'hFF) return;
        zeros = $countones(~an);
        if (zeros > 1) begin
            exp_err++;
            return;
        end
        d = 0;
        for (int i = 0; i < 8; i++) if (an[i] == 1'b0) d = i;
        val = -1;
        for (int n = 0; n < 16; n++) if (pat[n] == seg) val = n;
        if (val < 0) begin
            exp_err++;
            m_bad = 1'b1;
            val   = 0;
        end
        m_val[d] = 4'(val);
        m_cov[d] = 1'b1;
        m_dp[d]  = DP_EN & lit;
        all = 1'b1;
        for (int i = 0; i < 8; i++) if (!m_cov[i]) all = 1'b0;
        if (all) begin
            dat = '0;
            dpv = '0;
            for (int i = 0; i < 8; i++) begin
                dat[4*i +: 4] = m_val[i];
                dpv[i]        = m_dp[i];
            end
            exp_q.push_back({m_bad, dpv, dat});
            model_clear();
        end
    endtask

    task automatic strobe(input logic [7:0] an, input logic [6:0] seg, input bit lit, input int len);
        an_r       = an;
        seg_r      = seg;
        dp_n       = ~lit;
        last_start = cyc;
        prev_an    = an;
        model_strobe(an, seg, lit, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int len);
        strobe(8'hFF, 7'h7F, 1'b0, len);
    endtask

    task automatic scan_digit(input logic [31:0] word, input int idx, input bit lit, input int len);
        logic [7:0] a;
        a = 8'd1 << idx;
        strobe(~a, pat[word[4*idx +: 4]], lit, len);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b1;
        an_r  = 8'hFF;
        seg_r = 7'h7F;
        dp_n  = 1'b1;
        prev_an = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h required 00000000", data); end
        tests_run++;
        if (dp !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_dp: got %h required 00", dp); end
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b required 0", valid); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_err: got %b required 0", frame_err); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b required 0", err); end
        for (int i = 0; i < 8; i++) scan_digit(32'h5A5A5A5A, i, 1'b1, 20);
        idle(25);
        do_reset();
        tests_run++;
        if (data !== 32'h0 || dp !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_frame: got data %h dp %h required 00000000 00", data, dp);
        end
    endtask

    task automatic test_known_word();
        int vb;
        int eb;
        int p8;
        do_reset();
        vb = valid_total;
        eb = err_total;
        for (int i = 0; i < 8; i++) scan_digit(32'h1234ABCD, i, 1'b0, 20);
        p8 = last_start;
        idle(25);
        tests_run++;
        if (valid_total - vb !== 1) begin tests_failed++; $display("[TB] FAIL known_valid_count: got %0d required 1", valid_total - vb); end
        tests_run++;
        if (data !== 32'h1234ABCD) begin tests_failed++; $display("[TB] FAIL known_data: got %h required 1234abcd", data); end
        tests_run++;
        if (frame_err !== 1'b0 || dp !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL known_flags: got frame_err %b dp %h required 0 00", frame_err, dp);
        end
        tests_run++;
        if (err_total - eb !== 0) begin tests_failed++; $display("[TB] FAIL known_err: got %0d pulses required 0", err_total - eb); end
        tests_run++;
        if (valid_cyc - p8 < SC + 1 || valid_cyc - p8 > SC + 2) begin
            tests_failed++;
            $display("[TB] FAIL known_latency: got %0d cycles required %0d..%0d", valid_cyc - p8, SC + 1, SC + 2);
        end
    endtask

    task automatic test_dp_capture();
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) strobe(~(8'd1 << i), 7'h00, (i == 0 || i == 7), 20);
        idle(25);
        want = DP_EN ? 8'h81 : 8'h00;
        tests_run++;
        if (data !== 32'h88888888) begin tests_failed++; $display("[TB] FAIL dp_data: got %h required 88888888", data); end
        tests_run++;
        if (dp !== want) begin tests_failed++; $display("[TB] FAIL dp_bits: got %h required %h", dp, want); end
    endtask

    task automatic test_bad_digit();
        int eb;
        int vb;
        int p3;
        do_reset();
        eb = err_total;
        vb = valid_total;
        p3 = 0;
        for (int i = 0; i < 8; i++) begin
            strobe(~(8'd1 << i), (i == 3) ? 7'h7F : 7'h40, 1'b0, 20);
            if (i == 3) p3 = last_start;
        end
        idle(25);
        tests_run++;
        if (err_total - eb !== 1) begin tests_failed++; $display("[TB] FAIL bad_err_count: got %0d required 1", err_total - eb); end
        tests_run++;
        if (err_cyc - p3 < SC || err_cyc - p3 > SC + 1) begin
            tests_failed++;
            $display("[TB] FAIL bad_err_timing: got %0d cycles required %0d..%0d", err_cyc - p3, SC, SC + 1);
        end
        tests_run++;
        if (valid_total - vb !== 1 || data !== 32'h0 || frame_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bad_frame: got valids %0d data %h frame_err %b required 1 00000000 1",
                     valid_total - vb, data, frame_err);
        end
    endtask

    task automatic test_glitch();
        int vb;
        int eb;
        do_reset();
        vb = valid_total;
        eb = err_total;
        for (int i = 0; i < 8; i++) scan_digit(32'hFEDCBA98, i, 1'b0, 10);
        for (int i = 0; i < 8; i++) scan_digit(32'hFEDCBA98, i, 1'b0, SC);
        tests_run++;
        if (valid_total - vb !== 0 || err_total - eb !== 0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_ignored: got valids %0d errs %0d required 0 0", valid_total - vb, err_total - eb);
        end
        for (int i = 0; i < 8; i++) scan_digit(32'hFEDCBA98, i, 1'b0, SC + 1);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 1 || data !== 32'hFEDCBA98) begin
            tests_failed++;
            $display("[TB] FAIL glitch_recover: got valids %0d data %h required 1 fedcba98", valid_total - vb, data);
        end
    endtask

    task automatic test_multi_anode();
        int vb;
        int eb;
        do_reset();
        vb = valid_total;
        eb = err_total;
        strobe(8'hFC, pat[5], 1'b0, 40);
        tests_run++;
        if (err_total - eb !== 1) begin tests_failed++; $display("[TB] FAIL multi_err: got %0d required 1", err_total - eb); end
        for (int i = 2; i < 8; i++) scan_digit(32'h76543210, i, 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 0) begin tests_failed++; $display("[TB] FAIL multi_no_mask: got %0d valids required 0", valid_total - vb); end
        scan_digit(32'h76543210, 0, 1'b0, 20);
        scan_digit(32'h76543210, 1, 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 1 || data !== 32'h76543210) begin
            tests_failed++;
            $display("[TB] FAIL multi_complete: got valids %0d data %h required 1 76543210", valid_total - vb, data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int vb;
        int order [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
        do_reset();
        for (int i = 0; i < 5; i++) scan_digit(32'hCAFE0123, i, 1'b0, 20);
        do_reset();
        vb = valid_total;
        for (int k = 0; k < 7; k++) scan_digit(32'h89ABCDEF, order[k], 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 0) begin tests_failed++; $display("[TB] FAIL midreset_early: got %0d valids required 0", valid_total - vb); end
        scan_digit(32'h89ABCDEF, order[7], 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 1 || data !== 32'h89ABCDEF) begin
            tests_failed++;
            $display("[TB] FAIL midreset_frame: got valids %0d data %h required 1 89abcdef", valid_total - vb, data);
        end
    endtask

    task automatic test_enable();
        int vb;
        int eb;
        do_reset();
        for (int i = 0; i < 8; i++) scan_digit(32'h0BADF00D, i, 1'b0, 20);
        idle(25);
        vb = valid_total;
        eb = err_total;
        for (int i = 0; i < 4; i++) scan_digit(32'h13579BDF, i, 1'b0, 20);
        en = 1'b0;
        for (int i = 4; i < 8; i++) scan_digit(32'h13579BDF, i, 1'b0, 20);
        strobe(8'h00, 7'h7F, 1'b0, 30);
        en = 1'b1;
        for (int i = 4; i < 8; i++) scan_digit(32'h13579BDF, i, 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 0 || err_total - eb !== 0 || data !== 32'h0BADF00D) begin
            tests_failed++;
            $display("[TB] FAIL enable_hold: got valids %0d errs %0d data %h required 0 0 0badf00d",
                     valid_total - vb, err_total - eb, data);
        end
        for (int i = 0; i < 8; i++) scan_digit(32'h13579BDF, i, 1'b0, 20);
        idle(25);
        tests_run++;
        if (valid_total - vb !== 1 || data !== 32'h13579BDF) begin
            tests_failed++;
            $display("[TB] FAIL enable_resume: got valids %0d data %h required 1 13579bdf", valid_total - vb, data);
        end
    endtask

    task automatic test_random();
        int gb;
        int qb;
        int eb;
        int xb;
        int n;
        int r;
        int len;
        int lens [6] = '{6, SC, SC + 1, SC + 1, 24, 24};
        logic [7:0] a;
        logic [6:0] s;
        do_reset();
        gb = got_q.size();
        qb = exp_q.size();
        eb = err_total;
        xb = exp_err;
        for (int k = 0; k < 150; k++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 8) begin
                    a = 8'd1 << $urandom_range(0, 7);
                    a = ~a;
                end else if (r == 8) begin
                    a = 8'hFF;
                end else begin
                    do a = 8'($urandom); while ($countones(~a) < 2);
                end
            end while (a == prev_an);
            if ($urandom_range(0, 4) != 0) s = pat[$urandom_range(0, 15)];
            else s = 7'($urandom);
            len = lens[$urandom_range(0, 5)];
            strobe(a, s, 1'($urandom), len);
        end
        idle(25);
        tests_run++;
        if (got_q.size() - gb !== exp_q.size() - qb) begin
            tests_failed++;
            $display("[TB] FAIL random_frames: got %0d required %0d", got_q.size() - gb, exp_q.size() - qb);
        end
        tests_run++;
        if (err_total - eb !== exp_err - xb) begin
            tests_failed++;
            $display("[TB] FAIL random_errs: got %0d required %0d", err_total - eb, exp_err - xb);
        end
        n = got_q.size() - gb;
        if (exp_q.size() - qb < n) n = exp_q.size() - qb;
        for (int k = 0; k < n; k++) begin
            tests_run++;
            if (got_q[gb + k] !== exp_q[qb + k]) begin
                tests_failed++;
                $display("[TB] FAIL random_frame_%0d: got %h required %h", k, got_q[gb + k], exp_q[qb + k]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        an_r  = 8'hFF;
        seg_r = 7'h7F;
        dp_n  = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_known_word();
        test_dp_capture();
        test_bad_digit();
        test_glitch();
        test_multi_anode();
        test_reset_mid_frame();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side counterpart of the multiplexed seven-segment display driver: samples the scanned cathode (CA..CG, DP) and anode (AN) lines, waits for each strobe to settle, decodes each lit digit back to a hex nibble and reassembles the 32-bit word the driver is showing. It sits alongside the display path for loopback self-check on the board and as a bench monitor. It publishes one word per completed scan frame.

## Interface
- CLK_FREQUENCY, 100_000_000, system clock rate in Hz; documentation only, no functional use.
- STABLE_CYCLES, 16, consecutive unchanged samples required before a digit is accepted; legal range 2..65535.
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high (this polarity and synchronicity are fixed).
- en  input  1  capture enable.
- CA, CB, CC, CD, CE, CF, CG  input  1 each  segment cathodes, active-low.
- DP  input  1  decimal-point cathode, active-low.
- AN  input  8  digit anodes, active-low; AN[i] low selects digit i, where digit i is nibble data[4i+3:4i].
- data  output  32  last completed frame.
- dp  output  8  decimal points of last frame; dp[i] = 1 means the point was lit.
- valid  output  1  one-cycle pulse; data, dp and frame_err are updated on this cycle.
- frame_err  output  1  qualifies valid: at least one digit in the frame was undecodable.
- err  output  1  one-cycle pulse on any protocol or decode error.

## Operation
- All inputs are registered once into a sample vector S = {AN, DP, CG..CA}.
- The stability counter clears when S differs from the previous sample; otherwise it increments and saturates at STABLE_CYCLES-1.
- A per-strobe "taken" flag clears on any change of S. This guarantees one acceptance per strobe.
- Acceptance happens when all of the following hold: counter == STABLE_CYCLES-1, taken == 0 and en == 1.
  - AN all ones (blank): no action.
  - AN with exactly one zero at bit i: decode the segments, write the nibble into shadow[i], the DP state into dpshadow[i], set mask[i], set taken.
  - AN with two or more zeros: pulse err, set taken, store nothing.
- Decode uses segment vector {CG,CF,CE,CD,CC,CB,CA}, active-low, hex patterns:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Any other pattern stores nibble 0, pulses err and sets the sticky frame-error flag.
- Re-accepting a digit already in mask overwrites it (last value wins); mask stays set.
- When mask == 8'hFF:
  - data <= shadow, dp <= dpshadow, frame_err <= sticky flag.
  - Pulse valid.
  - Clear mask and the sticky flag.
- en low: counter and mask are forced to 0 and the sticky flag is cleared. data and dp hold their values; no valid or err pulses.

## Timing
- Reset values: data 0, dp 0, valid 0, frame_err 0, err 0; mask, counter, taken, shadow and sticky flag all 0.
- A strobe applied at cycle t (the first cycle the new pin values are present) is accepted at cycle t+STABLE_CYCLES. The extra cycle is the input register.
- err pulses in the acceptance cycle.
- valid asserts one cycle after the eighth distinct digit is accepted.
- A strobe shorter than STABLE_CYCLES+1 cycles is ignored.
- A steady strobe held indefinitely is accepted exactly once.
- rst mid-frame discards the partial frame; the next valid requires all 8 digits again.
- Scan order is irrelevant; frames complete on coverage of all 8 digits, not on order.

## Configuration
- SEG_CAPTURE_DP_EN defined: DP is part of S, captured per digit and presented on dp.
- SEG_CAPTURE_DP_EN undefined: DP is ignored, including in the stability compare, and dp is constant 0.

## Structure
- Package seg_pkg holds:
  - the segment-pattern constants for 0..F;
  - digit count (8), nibble width (4), segment width (7).
- Sub-module seg_decode: combinational 7-bit pattern to {hit, nibble[3:0]}. It is shared later with any other segment consumer.
- seg_capture holds the sampler, stability counter, acceptance logic, shadow registers and frame assembly.

## Test plan
- Scan 8 digits showing 32'h1234ABCD (digit 0 = D, pattern 21), 20 cycles per strobe, DP off -> one valid pulse, data = 32'h1234ABCD, frame_err = 0, dp = 8'h00.
- Scan all digits with segments 7'h00 ("8") and DP low on digits 0 and 7 -> data = 32'h88888888; dp = 8'h81 with SEG_CAPTURE_DP_EN defined, 8'h00 without it.
- Digit 3 shows pattern 7'h7F (blank), others show 7'h40 -> err pulse at the digit-3 acceptance, data = 32'h00000000, frame_err = 1.
- Glitchy strobes of 10 cycles with STABLE_CYCLES = 16 -> no acceptance and no valid; then 20-cycle strobes -> valid after 8 strobes.
- AN = 8'hFC held 40 cycles -> a single err pulse and no mask change.
- Assert rst after 5 digits accepted, then resume a full scan -> exactly one valid and only after all 8 digits are accepted post-reset.
